alt_vipvfr140_prc_queue_core: RTL
=================================

Name: alt_vipvfr140_prc_queue_core

Overview:
- Next-generation packet reader core. Accepts a queue of up to DESC_DEPTH packet descriptors.
- For each descriptor it emits one Avalon-ST video packet: a header beat carrying the packet type with SOP, then the sample beats, with EOP on the last beat.
- Sample data is fetched through a command/read-data master interface, split into bursts of at most MAX_BURST.
- Sits between the control slave and the Avalon-MM read master, in the frame-reader datapath.

Parameters:
- BITS_PER_SYMBOL, 8, bits per colour symbol
- SYMBOLS_PER_BEAT, 3, symbols per sample beat; DW = BITS_PER_SYMBOL*SYMBOLS_PER_BEAT
- PACKET_SAMPLES_REQUIREDWIDTH, 32, width of the samples count
- BURST_LENGTH_REQUIREDWIDTH, 7, width of cmd_length_of_burst
- MAX_BURST, 64, maximum samples per command; must be ≤ 2^BURST_LENGTH_REQUIREDWIDTH-1
- WORD_BYTES, 4, address increment per sample
- DESC_DEPTH, 4, descriptor FIFO depth; power of two, ≥2

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high reset
- desc_valid  in  1  descriptor offered
- desc_ready  out  1  FIFO not full
- desc_addr  in  32  packet base byte address
- desc_type  in  4  packet type
- desc_samples  in  PACKET_SAMPLES_REQUIREDWIDTH  sample count
- cmd  out  1  burst command valid
- cmd_ready  in  1  master accepts command
- cmd_addr  out  32  burst byte address
- cmd_length_of_burst  out  BURST_LENGTH_REQUIREDWIDTH  burst length in samples
- rdata_valid  in  1  read-data beat valid
- rdata_ready  out  1  core can accept a beat
- rdata  in  DW  read-data sample
- ready_out  in  1  sink ready
- valid_out  out  1  source valid
- data_out  out  DW  source data
- sop_out  out  1  start of packet
- eop_out  out  1  end of packet
- busy  out  1  packet in progress
- complete  out  1  one-cycle pulse after the EOP handshake
- queue_level  out  $clog2(DESC_DEPTH)+1  descriptors queued

Behaviour:
- Reset values:
  - All outputs 0, except desc_ready=1.
  - FIFO emptied; FSM in IDLE.
  - Reset mid-packet abandons the packet with no EOP; in-flight read data arriving after reset is accepted and dropped.
- Descriptor FIFO:
  - Push on desc_valid&desc_ready; desc_ready = (queue_level<DESC_DEPTH).
  - Pop happens in IDLE.
  - Simultaneous push and pop leaves queue_level unchanged.
  - Pointers wrap modulo DESC_DEPTH.
- Output stage:
  - Registered 2-entry skid buffer. valid_out, data_out, sop_out and eop_out come from the buffer head.
  - A beat transfers on valid_out&ready_out.
  - Data/sop/eop hold stable while valid_out&!ready_out.
- FSM states and transitions:
  - IDLE: if queue non-empty, pop the descriptor, latch addr/type/samples, set busy=1, go to HEADER.
  - HEADER: push one beat into the skid buffer when it has space:
    - data = {zeros, type}, sop=1.
    - eop=1 only if samples==0; then go to DRAIN.
    - Otherwise go to CMD.
  - CMD: assert cmd with cmd_addr = current address and length = min(remaining_cmd, MAX_BURST).
    - On cmd&cmd_ready: address += length*WORD_BYTES (32-bit wrap), remaining_cmd -= length.
    - If remaining_cmd reaches 0, go to DATA; otherwise stay in CMD.
    - cmd holds high with stable fields until accepted.
  - DATA: rdata_ready = skid buffer has a free entry.
    - Each accepted beat decrements remaining_data.
    - The beat taking remaining_data to 0 carries eop=1; then go to DRAIN.
    - Beats accepted while the FSM is in CMD are also counted (commands and data overlap).
  - DRAIN: wait until the EOP beat has transferred. Then:
    - complete pulses high for one cycle.
    - busy falls.
    - Return to IDLE.
    - The next descriptor may pop in the same cycle complete is asserted.
- Latency:
  - Accepted rdata beat appears on data_out on the next cycle when the buffer is empty.
  - Descriptor push to header valid_out is 3 cycles when idle.
- Arithmetic:
  - Counters are PACKET_SAMPLES_REQUIREDWIDTH wide.
  - min() compares against MAX_BURST zero-extended.
- Protocol rules:
  - rdata_valid while rdata_ready=0 is not allowed; the master must hold the beat.
  - rdata_valid outside an active packet is dropped.

Optional Feature:
- Macro PRC_FRAME_REPEAT_EN.
- With the macro:
  - Adds input port repeat_enable (1 bit).
  - The last popped descriptor is retained in a shadow register, marked valid after the first pop.
  - In IDLE with the FIFO empty, repeat_enable=1 and a valid shadow, the shadow descriptor is replayed as if popped; queue_level is unchanged.
  - A queued descriptor always takes priority over a repeat.
  - Reset invalidates the shadow.
- Without the macro: no port and no shadow register; IDLE waits for a queued descriptor.

Test Plan:
- Push {addr=0x1000, type=0, samples=3}, ready_out=1, read data returned immediately → header beat data=0 sop=1; cmd addr=0x1000 len=3; 3 data beats, eop on the 3rd; complete pulses once; busy back to 0.
- samples=150, MAX_BURST=64 → commands (0x2000,64), (0x2100,64), (0x2200,22); 150 data beats; exactly one eop.
- samples=0, type=0xF → single beat data=0xF with sop=1 and eop=1; no cmd asserted; complete pulses.
- Push 5 descriptors back-to-back (DESC_DEPTH=4) → desc_ready low after 4 queued in FIFO; queue_level reaches 4; all 5 packets emitted in order.
- Toggle ready_out randomly mid-packet → data_out/sop/eop stable while stalled; rdata_ready deasserts when 2 beats are buffered; no beat lost or duplicated.
- reset asserted during DATA, then new descriptor samples=2 → outputs return to reset values; next packet emits a clean header + 2 beats; (PRC_FRAME_REPEAT_EN) with repeat_enable=1 and FIFO empty, the last descriptor replays continuously until a new one is pushed.

Source files
------------

// File: rtl/alt_vipvfr140_prc_queue_core.sv
// alt_vipvfr140_prc_queue_core: descriptor-queued packet reader core.
// Queues descriptors, issues burst read commands and emits one Avalon-ST
// packet per descriptor (type header beat, then sample beats).
// Optional feature macro: PRC_FRAME_REPEAT_EN (repeat_enable port and
// replay of the last popped descriptor while the queue is empty).
module alt_vipvfr140_prc_queue_core #(
  parameter int unsigned BITS_PER_SYMBOL              = 8,
  parameter int unsigned SYMBOLS_PER_BEAT             = 3,
  parameter int unsigned PACKET_SAMPLES_REQUIREDWIDTH = 32,
  parameter int unsigned BURST_LENGTH_REQUIREDWIDTH   = 7,
  parameter int unsigned MAX_BURST                    = 64,
  parameter int unsigned WORD_BYTES                   = 4,
  parameter int unsigned DESC_DEPTH                   = 4
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          desc_valid,
  output logic                                          desc_ready,
  input  logic [31:0]                                   desc_addr,
  input  logic [3:0]                                    desc_type,
  input  logic [PACKET_SAMPLES_REQUIREDWIDTH-1:0]       desc_samples,
  output logic                                          cmd,
  input  logic                                          cmd_ready,
  output logic [31:0]                                   cmd_addr,
  output logic [BURST_LENGTH_REQUIREDWIDTH-1:0]         cmd_length_of_burst,
  input  logic                                          rdata_valid,
  output logic                                          rdata_ready,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0]   rdata,
  input  logic                                          ready_out,
  output logic                                          valid_out,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0]   data_out,
  output logic                                          sop_out,
  output logic                                          eop_out,
  output logic                                          busy,
  output logic                                          complete,
  output logic [$clog2(DESC_DEPTH):0]                   queue_level
`ifdef PRC_FRAME_REPEAT_EN
  ,
  input  logic                                          repeat_enable
`endif
);

  localparam int unsigned DW  = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int unsigned SW  = PACKET_SAMPLES_REQUIREDWIDTH;
  localparam int unsigned BLW = BURST_LENGTH_REQUIREDWIDTH;
  localparam int unsigned PW  = $clog2(DESC_DEPTH);
  localparam int unsigned LW  = PW + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HEADER = 3'd1;
  localparam logic [2:0] S_CMD    = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  typedef struct packed {
    logic [31:0]   addr;
    logic [3:0]    ptype;
    logic [SW-1:0] samples;
  } desc_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  logic [2:0]     state_q, state_d;
  desc_t          fifo_q [DESC_DEPTH];
  desc_t          fifo_d [DESC_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           desc_ready_q, desc_ready_d;
  logic [31:0]    addr_q, addr_d;
  logic [3:0]     cur_type_q, cur_type_d;
  logic [SW-1:0]  rem_cmd_q, rem_cmd_d, rem_data_q, rem_data_d;
  logic           cmd_q, cmd_d;
  logic [BLW-1:0] cmd_len_q, cmd_len_d;
  beat_t          buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]     buf_cnt_q, buf_cnt_d;
  logic           valid_out_q, valid_out_d;
  logic           rdata_ready_q, rdata_ready_d;
  logic           busy_q, busy_d;
  logic           complete_q, complete_d;

  logic           push_desc, pop_desc, load;
  desc_t          load_desc;
  logic           pop_beat, push_beat, space, counting, counting_d, take_rdata;
  beat_t          new_beat;

`ifdef PRC_FRAME_REPEAT_EN
  desc_t          shadow_q, shadow_d;
  logic           shadow_valid_q, shadow_valid_d;
`endif

  // Next-state: descriptor FIFO, packet FSM, command issue and skid buffer.
  always_comb begin
    state_d     = state_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    addr_d      = addr_q;
    cur_type_d  = cur_type_q;
    rem_cmd_d   = rem_cmd_q;
    rem_data_d  = rem_data_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    buf_cnt_d   = buf_cnt_q;
    busy_d      = busy_q;
    complete_d  = 1'b0;
    push_desc   = desc_valid && desc_ready_q;
    pop_desc    = 1'b0;
    load        = 1'b0;
    load_desc   = fifo_q[rd_ptr_q];
    pop_beat    = valid_out_q && ready_out;
    push_beat   = 1'b0;
    new_beat    = '0;
    space       = (buf_cnt_q != 2'd2);
    counting    = ((state_q == S_CMD) || (state_q == S_DATA)) && (rem_data_q != '0);
    take_rdata  = rdata_valid && rdata_ready_q && counting;
`ifdef PRC_FRAME_REPEAT_EN
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop_desc = 1'b1;
          load     = 1'b1;
`ifdef PRC_FRAME_REPEAT_EN
        end else if (repeat_enable && shadow_valid_q) begin
          load      = 1'b1;
          load_desc = shadow_q;
`endif
        end
        if (load) begin
          addr_d     = load_desc.addr;
          cur_type_d = load_desc.ptype;
          rem_cmd_d  = load_desc.samples;
          rem_data_d = load_desc.samples;
          busy_d     = 1'b1;
          state_d    = S_HEADER;
        end
      end
      S_HEADER: begin
        if (space) begin
          push_beat     = 1'b1;
          new_beat.data = DW'(cur_type_q);
          new_beat.sop  = 1'b1;
          new_beat.eop  = (rem_data_q == '0);
          state_d       = (rem_data_q == '0) ? S_DRAIN : S_CMD;
        end
      end
      S_CMD: begin
        if (cmd_q && cmd_ready) begin
          addr_d    = addr_q + 32'(cmd_len_q) * 32'(WORD_BYTES);
          rem_cmd_d = rem_cmd_q - SW'(cmd_len_q);
          if (rem_cmd_d == '0) state_d = S_DATA;
        end
      end
      S_DATA: begin
      end
      S_DRAIN: begin
        if (pop_beat && buf0_q.eop) begin
          complete_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Read data is counted in both CMD and DATA since commands and data overlap.
    if (take_rdata) begin
      push_beat     = 1'b1;
      new_beat.data = rdata;
      new_beat.sop  = 1'b0;
      new_beat.eop  = (rem_data_q == SW'(1));
      rem_data_d    = rem_data_q - SW'(1);
      if (rem_data_q == SW'(1)) state_d = S_DRAIN;
    end

    if (push_desc) begin
      fifo_d[wr_ptr_q].addr    = desc_addr;
      fifo_d[wr_ptr_q].ptype   = desc_type;
      fifo_d[wr_ptr_q].samples = desc_samples;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_desc) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
`ifdef PRC_FRAME_REPEAT_EN
      shadow_d       = load_desc;
      shadow_valid_d = 1'b1;
`endif
    end
    case ({push_desc, pop_desc})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    desc_ready_d = (level_d < LW'(DESC_DEPTH));

    // Two-entry skid buffer; buf0 is the head driving the source outputs.
    if (pop_beat && push_beat) begin
      if (buf_cnt_q == 2'd1) begin
        buf0_d = new_beat;
      end else begin
        buf0_d = buf1_q;
        buf1_d = new_beat;
      end
    end else if (pop_beat) begin
      buf0_d    = buf1_q;
      buf_cnt_d = buf_cnt_q - 2'd1;
    end else if (push_beat) begin
      if (buf_cnt_q == 2'd0) buf0_d = new_beat;
      else                   buf1_d = new_beat;
      buf_cnt_d = buf_cnt_q + 2'd1;
    end
    valid_out_d = (buf_cnt_d != 2'd0);

    cmd_d     = (state_d == S_CMD);
    cmd_len_d = cmd_d ? ((rem_cmd_d > SW'(MAX_BURST)) ? BLW'(MAX_BURST) : BLW'(rem_cmd_d))
                      : '0;

    // Outside a counting phase read data is accepted and discarded.
    counting_d    = ((state_d == S_CMD) || (state_d == S_DATA)) && (rem_data_d != '0);
    rdata_ready_d = counting_d ? (buf_cnt_d != 2'd2) : 1'b1;
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      desc_ready_q  <= 1'b1;
      addr_q        <= '0;
      cur_type_q    <= '0;
      rem_cmd_q     <= '0;
      rem_data_q    <= '0;
      cmd_q         <= 1'b0;
      cmd_len_q     <= '0;
      buf0_q        <= '0;
      buf1_q        <= '0;
      buf_cnt_q     <= '0;
      valid_out_q   <= 1'b0;
      rdata_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      complete_q    <= 1'b0;
`ifdef PRC_FRAME_REPEAT_EN
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      desc_ready_q  <= desc_ready_d;
      addr_q        <= addr_d;
      cur_type_q    <= cur_type_d;
      rem_cmd_q     <= rem_cmd_d;
      rem_data_q    <= rem_data_d;
      cmd_q         <= cmd_d;
      cmd_len_q     <= cmd_len_d;
      buf0_q        <= buf0_d;
      buf1_q        <= buf1_d;
      buf_cnt_q     <= buf_cnt_d;
      valid_out_q   <= valid_out_d;
      rdata_ready_q <= rdata_ready_d;
      busy_q        <= busy_d;
      complete_q    <= complete_d;
`ifdef PRC_FRAME_REPEAT_EN
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
`endif
    end
  end

  // Descriptor storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    fifo_q <= fifo_d;
  end

  assign desc_ready          = desc_ready_q;
  assign queue_level         = level_q;
  assign cmd                 = cmd_q;
  assign cmd_addr            = addr_q;
  assign cmd_length_of_burst = cmd_len_q;
  assign rdata_ready         = rdata_ready_q;
  assign valid_out           = valid_out_q;
  assign data_out            = buf0_q.data;
  assign sop_out             = buf0_q.sop;
  assign eop_out             = buf0_q.eop;
  assign busy                = busy_q;
  assign complete            = complete_q;

endmodule
